// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: forwarding-select and load-use stall unit between ID and
// the EX/MEM pipeline. In-flight register writes are tracked in a shift
// register (entry 0 = EX, youngest). Each entry remembers the first stage at
// which its result can be forwarded.
// Optional feature: define HAZARD_SCOREBOARD_PERF_CNT_EN to add a saturating
// 32-bit stall counter output (stall_cnt).
module hazard_scoreboard #(
    parameter  int NUM_SRC = 2,
    parameter  int REG_AW  = 5,
    parameter  int NUM_FWD = 3,
    localparam int SW      = $clog2(NUM_FWD),
    localparam int FSW     = $clog2(NUM_FWD + 1)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_reg_write,
    input  logic [SW-1:0]             id_ready_stage,
    input  logic                      hold,
    input  logic                      flush,
`ifdef HAZARD_SCOREBOARD_PERF_CNT_EN
    output logic [31:0]               stall_cnt,
`endif
    output logic [NUM_SRC*FSW-1:0]    fwd_sel,
    output logic                      stall_id
);

    localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_FWD - 1);

    logic [NUM_FWD-1:0] e_valid;
    logic [REG_AW-1:0]  e_rd  [NUM_FWD];
    logic [SW-1:0]      e_rdy [NUM_FWD];
    logic [NUM_SRC-1:0] hazard;
    logic [SW-1:0]      rdy_in;

    // Clamp an out-of-range ready stage to the last tracked stage.
    always_comb begin
        rdy_in = id_ready_stage;
        if (id_ready_stage > LAST_STAGE) begin
            rdy_in = LAST_STAGE;
        end
    end

    // Per-source lookup: scan oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_sel = '0;
        hazard  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int s = NUM_FWD - 1; s >= 0; s--) begin
                if (id_valid && id_rs_used[i] && e_valid[s] &&
                    (e_rd[s] != '0) && (e_rd[s] == id_rs[i*REG_AW +: REG_AW])) begin
                    if (SW'(s) >= e_rdy[s]) begin
                        fwd_sel[i*FSW +: FSW] = FSW'(s + 1);
                        hazard[i]             = 1'b0;
                    end else begin
                        fwd_sel[i*FSW +: FSW] = '0;
                        hazard[i]             = 1'b1;
                    end
                end
            end
        end
        // A flush kills the ID instruction, so it must not stall.
        stall_id = (|hazard) & ~flush;
    end

    // Scoreboard advance: flush > hold > stall (bubble) > normal issue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_valid <= '0;
            for (int s = 0; s < NUM_FWD; s++) begin
                e_rd[s]  <= '0;
                e_rdy[s] <= '0;
            end
        end else if (flush) begin
            // Entry 0 (killed EX) and the new insert are both dropped.
            e_valid[0] <= 1'b0;
            for (int s = 1; s < NUM_FWD; s++) begin
                e_valid[s] <= (s == 1) ? 1'b0 : e_valid[s-1];
                e_rd[s]    <= e_rd[s-1];
                e_rdy[s]   <= e_rdy[s-1];
            end
        end else if (!hold) begin
            e_valid[0] <= stall_id ? 1'b0 : (id_valid & id_reg_write);
            e_rd[0]    <= id_rd;
            e_rdy[0]   <= rdy_in;
            for (int s = 1; s < NUM_FWD; s++) begin
                e_valid[s] <= e_valid[s-1];
                e_rd[s]    <= e_rd[s-1];
                e_rdy[s]   <= e_rdy[s-1];
            end
        end
    end

`ifdef HAZARD_SCOREBOARD_PERF_CNT_EN
    // Count cycles in which a stall actually cost a pipeline slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (stall_id && !hold && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (NUM_SRC=2, NUM_FWD=3). Each step pushes
// the expected {stall_id, fwd_sel[1], fwd_sel[0]} into exp_q; the value is
// popped and compared when outputs are sampled on the falling edge.
module tb_hazard_scoreboard;

  localparam int W = 5;

  logic        clk;
  logic        reset_n;
  logic        id_valid;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic [4:0]  id_rd;
  logic        id_reg_write;
  logic [1:0]  id_ready_stage;
  logic        hold;
  logic        flush;
  logic [3:0]  fwd_sel;
  logic        stall_id;
`ifdef HAZARD_SCOREBOARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] cnt_before;
`endif

  logic [W-1:0] exp_q[$];
  int           n_checks;
  int           n_errors;
  int           exp_cnt;

  hazard_scoreboard #(.NUM_SRC(2), .REG_AW(5), .NUM_FWD(3)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .id_valid       (id_valid),
    .id_rs          (id_rs),
    .id_rs_used     (id_rs_used),
    .id_rd          (id_rd),
    .id_reg_write   (id_reg_write),
    .id_ready_stage (id_ready_stage),
    .hold           (hold),
    .flush          (flush),
`ifdef HAZARD_SCOREBOARD_PERF_CNT_EN
    .stall_cnt      (stall_cnt),
`endif
    .fwd_sel        (fwd_sel),
    .stall_id       (stall_id)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // pop the oldest expectation and compare against the live outputs
  task automatic sample(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_empty_q"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, {27'd0, stall_id, fwd_sel}, {27'd0, e});
    end
  endtask

  // drive one ID cycle, record the expectation, sample, then advance
  task automatic step(input string tag, input logic v,
                      input logic [4:0] rs1, input logic [4:0] rs0, input logic [1:0] used,
                      input logic [4:0] rd, input logic wr, input logic [1:0] rdy,
                      input logic hd, input logic fl,
                      input logic e_stall, input logic [1:0] e_f1, input logic [1:0] e_f0);
    id_valid       = v;
    id_rs          = {rs1, rs0};
    id_rs_used     = used;
    id_rd          = rd;
    id_reg_write   = wr;
    id_ready_stage = rdy;
    hold           = hd;
    flush          = fl;
    exp_q.push_back({e_stall, e_f1, e_f0});
    if (e_stall && !hd) exp_cnt++;
    @(negedge clk);
    sample(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      step("idle", 1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_cnt  = 0;
    reset_n  = 1'b0;
    id_valid = 1'b1; id_rs = {5'd5, 5'd5}; id_rs_used = 2'b11;
    id_rd = 5'd0; id_reg_write = 1'b0; id_ready_stage = 2'd0;
    hold = 1'b0; flush = 1'b0;

    // reset state
    exp_q.push_back('0);
    #12;
    sample("reset_out");
`ifdef HAZARD_SCOREBOARD_PERF_CNT_EN
    check("reset_cnt", stall_cnt, 32'd0);
`endif
    @(posedge clk); #1;
    reset_n = 1'b1;

    // 1. reset asserted mid-stall clears outputs immediately
    step("rst_issue", 1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    id_rs = {5'd0, 5'd5}; id_rs_used = 2'b01; id_reg_write = 1'b0;
    exp_q.push_back({1'b1, 2'd0, 2'd0});
    @(negedge clk);
    sample("rst_prestall");
    #1 reset_n = 1'b0;
    exp_q.push_back('0);
    #1 sample("rst_async");
    exp_cnt = 0;
`ifdef HAZARD_SCOREBOARD_PERF_CNT_EN
    check("rst_cnt_async", stall_cnt, 32'd0);
`endif
    @(posedge clk); #1;
    reset_n = 1'b1;
    step("rst_after", 1'b1, 5'd0, 5'd5, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);

    // 2. ALU back-to-back: forward from EX, then MEM, then WB, then regfile
    step("alu_issue", 1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step("alu_fwd1",  1'b1, 5'd0, 5'd5, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1);
    step("alu_fwd2",  1'b1, 5'd0, 5'd5, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2);
    step("alu_fwd3",  1'b1, 5'd0, 5'd5, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3);
    step("alu_gone",  1'b1, 5'd0, 5'd5, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);

    // 3. load-use on source 1: one stall, then forward from MEM
    step("ld_issue",  1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step("ld_stall",  1'b1, 5'd7, 5'd0, 2'b10, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
    step("ld_fwd2",   1'b1, 5'd7, 5'd0, 2'b10, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0);

    // 4. youngest producer wins; x0 and unused operands never match
    step("pri_iss_a", 1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step("pri_iss_b", 1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step("pri_young", 1'b1, 5'd0, 5'd3, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1);
    step("x0_issue",  1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step("x0_use",    1'b1, 5'd0, 5'd0, 2'b11, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step("unu_issue", 1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step("unu_use",   1'b1, 5'd9, 5'd9, 2'b00, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);

    // long latency with ready_stage=3 clamped to 2: two stalls, then fwd 3
    step("clm_issue", 1'b1, 5'd0, 5'd0, 2'b00, 5'd10, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step("clm_st1",   1'b1, 5'd10, 5'd0, 2'b10, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
    step("clm_st2",   1'b1, 5'd10, 5'd0, 2'b10, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
    step("clm_fwd3",  1'b1, 5'd10, 5'd0, 2'b10, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0);

    // 5. flush masks the stall and kills the pending load
    step("fl_issue",  1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step("fl_cycle",  1'b1, 5'd0, 5'd7, 2'b01, 5'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0);
    step("fl_after",  1'b1, 5'd0, 5'd7, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);

    // 6. hold during a load-use stall: 3 held cycles + 1 real stall
    step("hd_issue",  1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
`ifdef HAZARD_SCOREBOARD_PERF_CNT_EN
    cnt_before = stall_cnt;
`endif
    for (int k = 0; k < 3; k++) begin
      step("hd_held", 1'b1, 5'd7, 5'd0, 2'b10, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0);
    end
    step("hd_stall",  1'b1, 5'd7, 5'd0, 2'b10, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
    step("hd_fwd2",   1'b1, 5'd7, 5'd0, 2'b10, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0);
`ifdef HAZARD_SCOREBOARD_PERF_CNT_EN
    check("hd_cnt_delta", stall_cnt - cnt_before, 32'd1);
    check("total_cnt", stall_cnt, exp_cnt);
`endif
    idle(3);

    check("q_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised forwarding and hazard-detection unit that sits between the ID stage and the execute/memory pipeline. It tracks in-flight register writes in a shift-register scoreboard covering `NUM_FWD` forwarding stages. Each entry records the stage at which its result becomes forwardable. For every source operand in ID it produces a forward-select, and it raises a load-use (or long-latency) stall when a matching producer's result is not yet available.

## Interface

**Parameters**
- `NUM_SRC`, 2: number of source operands checked per instruction.
- `REG_AW`, 5: register address width.
- `NUM_FWD`, 3: number of forwarding stages tracked (stage 0 = EX, youngest).
- Derived, not overridable:
  - `SW = $clog2(NUM_FWD)`
  - `FSW = $clog2(NUM_FWD+1)`

**Ports**
- `clk`, input, 1: clock, rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `id_valid`, input, 1: instruction present in ID.
- `id_rs`, input, NUM_SRC*REG_AW: source register addresses; source i occupies bits [i*REG_AW +: REG_AW].
- `id_rs_used`, input, NUM_SRC: per-source "operand actually read" flag.
- `id_rd`, input, REG_AW: destination register of the ID instruction.
- `id_reg_write`, input, 1: ID instruction writes `id_rd`.
- `id_ready_stage`, input, SW: first stage index at which the result is forwardable (0 = EX output, 1 = MEM, ...).
- `hold`, input, 1: global pipeline freeze (e.g. memory wait).
- `flush`, input, 1: kill the instructions in ID and EX (branch redirect).
- `fwd_sel`, output, NUM_SRC*FSW: per-source select.
  - 0 = register file.
  - k = stage k-1 result.
- `stall_id`, output, 1: ID must not advance; a bubble is inserted into EX.

## Operation

**Scoreboard**
- Entries 0..NUM_FWD-1, one per stage.
- Each entry holds `valid`, `rd`, `rdy_stage`.
- Entry s is *ready* iff s >= `rdy_stage`.
- An entry matches source i iff all of the following hold:
  - `valid`
  - `rd != 0`
  - `rd == rs_i`
  - `id_rs_used[i]`
  - `id_valid`
- Forward-select for source i:
  - Choose the lowest-index matching entry (youngest producer wins).
  - If that entry is ready, `fwd_sel[i] = s+1`.
  - If it is not ready, the source is hazarded and `fwd_sel[i] = 0`.
  - With no match, `fwd_sel[i] = 0`.
- `stall_id` is the OR of per-source hazards, masked to 0 when `flush=1`.
- Register x0 never matches and never stalls.
- `id_ready_stage >= NUM_FWD` is clamped to `NUM_FWD-1`.

**Update at each rising edge, in priority order**
1. `flush`:
   - Entry 0 and entry 1 become invalid (the EX instruction is killed; nothing is inserted).
   - Entries 2.. take old entries 1...
   - `flush` dominates `hold`.
2. `hold`: all entries keep their values.
3. `stall_id`:
   - Entry 0 becomes invalid (bubble).
   - Entries 1.. take old entries 0...
4. Otherwise:
   - Entry 0 takes `{id_valid & id_reg_write, id_rd, id_ready_stage}`.
   - Entries 1.. take old entries 0...

**General rules**
- The entry leaving the last stage is discarded; the register file is write-through, so no hazard remains.
- Entries are cleared as described regardless of age: no counters wrap, and nothing saturates except the optional counter.

## Timing

- `fwd_sel` and `stall_id` are purely combinational from the current scoreboard and the ID inputs, with zero-cycle latency.
- The scoreboard updates one cycle after issue.
- Stall duration for source i is max(0, `rdy_stage` − s) cycles, evaluated each cycle. Example: load with `rdy_stage=1` followed immediately by a consumer gives exactly 1 stall cycle.
- During `hold`, outputs stay valid for the frozen state. A stall asserted during `hold` persists until `hold` deasserts and the entry advances.
- Reset (asynchronous, any cycle, including mid-stall):
  - All entries become invalid immediately.
  - `fwd_sel = 0` for all sources and `stall_id = 0` while `reset_n` is low and on the first cycle after release.

## Configuration

Macro `HAZARD_SCOREBOARD_PERF_CNT_EN` controls an optional stall counter.

- **Defined:**
  - Adds output `stall_cnt`, 32 bits.
  - Increments on every edge where `stall_id=1` and `hold=0`.
  - Saturates at 32'hFFFF_FFFF.
  - Resets asynchronously to 0.
- **Undefined:** the port and counter are absent, and behaviour is otherwise identical.

## Test plan

All scenarios use `NUM_SRC=2`, `NUM_FWD=3`.

1. **Reset:** issue rd=5, then assert `reset_n=0` mid-stall → `stall_id=0` and `fwd_sel=0` immediately. After release, a consumer of x5 sees `fwd_sel=0`.
2. **ALU back-to-back:** issue rd=5 with `ready_stage=0`. Next cycle, source 0 = x5 → `fwd_sel[0]=1`, `stall_id=0`. One cycle later → `fwd_sel[0]=2`.
3. **Load-use:** issue rd=7 with `ready_stage=1`. Next cycle, source 1 = x7 → `stall_id=1` for exactly 1 cycle, then `fwd_sel[1]=2`, `stall_id=0`.
4. **Priority and x0:**
   - Entries 0 and 1 both have rd=3 → `fwd_sel=1`.
   - rd=0 producer with consumer of x0 → `fwd_sel=0`, no stall.
   - `id_rs_used=0` → no stall.
5. **Flush:** pending load rd=7 in entry 0 while a consumer of x7 is in ID, with `flush=1` → `stall_id=0` this cycle. Next cycle, entries 0 and 1 are invalid and `fwd_sel=0`.
6. **Hold:** during the load-use stall, assert `hold` for 3 cycles → `stall_id` stays 1 for 3+1 cycles. With the macro defined, `stall_cnt=1`.
